// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 4-digit seven-segment scan driver.
// All patterns are active-low: a 0 bit lights a segment or enables a digit.
package seg7_pkg;

    typedef enum logic [2:0] {
        SIdle,
        DTens,
        DDirL,
        DDirH,
        DUnits
    } slot_e;

    localparam logic [3:0] AN_TENS  = 4'b1110;
    localparam logic [3:0] AN_DIR_L = 4'b1101;
    localparam logic [3:0] AN_DIR_H = 4'b1011;
    localparam logic [3:0] AN_UNITS = 4'b0111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_UP    = 7'b0011100;
    localparam logic [6:0] SEG_DOWN  = 7'b0100011;

    // seg[6:0] = g..a; codes above 9 never occur after the tens/units split
    function automatic logic [6:0] digit_glyph(input logic [3:0] digit);
        logic [6:0] pattern;
        unique case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: counter value/direction and enable in, digit/segment pins out.
interface seg7_scan_driver_if;
    logic       disp_en;
    logic [3:0] value;
    logic       dir;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_start;

    modport master (
        output disp_en, value, dir,
        input  an, seg, frame_start
    );

    modport slave (
        input  disp_en, value, dir,
        output an, seg, frame_start
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational decimal digit to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);
    assign pattern = digit_glyph(digit);
endmodule

// File: rtl/seg7_scan_driver.sv
// Four-slot multiplexed display scan: tens, direction (twice), units, with a
// per-frame snapshot of the counter and a blank gap cycle at each slot start.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 131072,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    slot_e         state_q, state_d;
    logic [3:0]    shadow_val_q;
    logic          shadow_dir_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_start_q;
    logic          tick, snap;

    logic          ge_ten;
    logic [3:0]    tens, units;
    logic [6:0]    tens_seg, units_seg, dir_seg;

    assign tick   = (pcnt_q == PMAX);
    assign ge_ten = (shadow_val_q >= 4'd10);
    assign tens   = ge_ten ? 4'd1 : 4'd0;
    assign units  = ge_ten ? shadow_val_q - 4'd10 : shadow_val_q;
    assign dir_seg = shadow_dir_q ? SEG_UP : SEG_DOWN;

    seg7_decode u_tens_dec (
        .digit   (tens),
        .pattern (tens_seg)
    );

    seg7_decode u_units_dec (
        .digit   (units),
        .pattern (units_seg)
    );

    always_comb begin
        pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                SIdle:   state_d = DTens;
                DTens:   state_d = DDirL;
                DDirL:   state_d = DDirH;
                DDirH:   state_d = DUnits;
                DUnits:  state_d = DTens;
                default: state_d = SIdle;
            endcase
        end
        snap = tick && (state_d == DTens);

        // Pins lag state/pcnt by one cycle; pcnt == 0 is the anti-ghosting gap.
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (pcnt_q != '0) begin
            unique case (state_q)
                DTens: begin
                    an_d  = AN_TENS;
                    seg_d = (BLANK_LZ && tens == 4'd0) ? SEG_BLANK : tens_seg;
                end
                DDirL: begin
                    an_d  = AN_DIR_L;
                    seg_d = dir_seg;
                end
                DDirH: begin
                    an_d  = AN_DIR_H;
                    seg_d = dir_seg;
                end
                DUnits: begin
                    an_d  = AN_UNITS;
                    seg_d = units_seg;
                end
                default: begin
                    an_d  = AN_OFF;
                    seg_d = SEG_BLANK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q        <= '0;
            state_q       <= SIdle;
            shadow_val_q  <= 4'd0;
            shadow_dir_q  <= 1'b1;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= snap;
            if (snap) begin
                shadow_val_q <= bus.value;
                shadow_dir_q <= bus.dir;
            end
        end
    end

    // Enable gating is deliberately combinational so blanking is immediate.
    assign bus.an          = bus.disp_en ? an_q : AN_OFF;
    assign bus.seg         = bus.disp_en ? seg_q : SEG_BLANK;
    assign bus.frame_start = frame_start_q;

endmodule
